ysyx_25020037_ifu: RTL

- Instruction fetch unit of the multi-cycle core. Sits directly upstream of the decode stage.
- Holds the architectural PC and issues one single-beat read per instruction on an AXI4-Lite-style read channel (AR/R only).
- Presents {pc, inst} to decode with a valid/ready handshake, then waits for the write-back stage to return the next PC before fetching again.

---
 rtl/ysyx_25020037_ifu.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ysyx_25020037_ifu.sv
// Instruction fetch unit: holds the PC, issues one AR/R read per instruction,
// hands {pc, inst, fetch_err} to decode, then waits for write-back's next PC.
module ysyx_25020037_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              next_pc_valid,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              ifu_rvalid,
  input  logic              idu_ready,
  output logic              fetch_err
);

  // Handshakes: a transfer happens in the cycle where valid and ready are both
  // high at the rising edge; a source holds valid and its payload stable until
  // that cycle, and a sink may raise or drop ready freely.

  typedef enum logic [1:0] {
    S_AR      = 2'd0,
    S_R       = 2'd1,
    S_OUT     = 2'd2,
    S_WAIT_PC = 2'd3
  } state_t;

  // Exposed for hierarchical probing by checkers.
  state_t state;

  logic ar_fire;
  logic r_fire;
  logic id_fire;
  logic next_pc_aligned;

  assign ar_fire         = arvalid && arready;
  assign r_fire          = rvalid && rready;
  assign id_fire         = ifu_rvalid && idu_ready;
  assign next_pc_aligned = (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_AR;
      pc         <= RESET_PC[ADDR_W-1:0];
      araddr     <= RESET_PC[ADDR_W-1:0];
      arvalid    <= 1'b1;
      rready     <= 1'b0;
      inst       <= 32'h0;
      ifu_rvalid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        S_AR: begin
          if (ar_fire) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_R;
          end
        end

        // idu_ready is irrelevant here: data is only registered on r_fire.
        S_R: begin
          if (r_fire) begin
            rready     <= 1'b0;
            ifu_rvalid <= 1'b1;
            if (rresp == 2'b00) begin
              inst      <= rdata;
              fetch_err <= 1'b0;
            end else begin
              inst      <= 32'h0;
              fetch_err <= 1'b1;
            end
            state <= S_OUT;
          end
        end

        S_OUT: begin
          if (id_fire) begin
            ifu_rvalid <= 1'b0;
            state      <= S_WAIT_PC;
          end
        end

        // A misaligned target never reaches the bus; it is reported as a fault.
        S_WAIT_PC: begin
          if (next_pc_valid) begin
            pc     <= next_pc;
            araddr <= next_pc;
            if (next_pc_aligned) begin
              arvalid <= 1'b1;
              state   <= S_AR;
            end else begin
              inst       <= 32'h0;
              fetch_err  <= 1'b1;
              ifu_rvalid <= 1'b1;
              state      <= S_OUT;
            end
          end
        end

        default: state <= S_AR;
      endcase
    end
  end

  a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
    !(arvalid && rready));

  a_arvalid_in_ar: assert property (@(posedge clk) disable iff (rst)
    arvalid |-> (state == S_AR));

  a_rready_in_r: assert property (@(posedge clk) disable iff (rst)
    rready |-> (state == S_R));

  a_ifu_rvalid_in_out: assert property (@(posedge clk) disable iff (rst)
    ifu_rvalid |-> (state == S_OUT));

  a_ar_stable: assert property (@(posedge clk) disable iff (rst)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    (ifu_rvalid && !idu_ready) |=>
      (ifu_rvalid && $stable(pc) && $stable(inst) && $stable(fetch_err)));

endmodule
